trap_controller: RTL and testbench
==================================

// Module: trap_controller
// PURPOSE
//  Consumes the {raise, code} exception struct and the machine interrupt lines, and performs M-mode trap entry.
//  Updates mepc/mcause/mtval/mstatus.{MIE,MPIE}, then issues a PC redirect to fetch. Also executes MRET.
//  Sits between the execute/commit stage and the fetch unit; it owns the trap CSRs, and the CSR file forwards accesses to them.
// PARAMETERS
//  XLEN        32           data/address width
//  RESET_MEPC  32'h0        reset value of mepc
// PORTS
//  clk             in   1     system clock
//  rst_n           in   1     reset: synchronous, active-low
//  exc_i           in   6     exception_t {raise, code[4:0]} from commit stage
//  exc_pc_i        in   XLEN  PC of the excepting/interrupted instruction
//  exc_tval_i      in   XLEN  trap value (faulting address / instruction bits)
//  mret_i          in   1     MRET committing this cycle
//  int_ok_i        in   1     commit boundary: interrupt may be taken at exc_pc_i
//  mip_i           in   3     {MEIP, MTIP, MSIP} pending lines
//  mie_i           in   3     {MEIE, MTIE, MSIE} enables
//  mtvec_i         in   XLEN  mtvec from CSR file (MODE in [1:0])
//  csr_we_i        in   1     software CSR write strobe
//  csr_addr_i      in   12    CSR address
//  csr_wdata_i     in   XLEN  CSR write data
//  redirect_valid_o out 1     redirect request to fetch
//  redirect_ready_i in  1     fetch accepts redirect
//  redirect_pc_o   out  XLEN  target PC
//  busy_o          out  1     trap sequence in progress; pipeline must stall/flush
//  mepc_o mcause_o mtval_o  out XLEN  current CSR values
//  mstatus_mie_o mstatus_mpie_o  out 1  mstatus bits
// BEHAVIOUR
//  Reset (rst_n=0 at posedge):
//    state=IDLE; redirect_valid_o=0, busy_o=0, redirect_pc_o=0
//    mepc=RESET_MEPC, mcause=0, mtval=0, MIE=0, MPIE=0
//  FSM: IDLE -> ENTER -> REDIRECT -> IDLE; IDLE -> RETURN -> REDIRECT -> IDLE.
//  IDLE: event selection, highest priority first:
//    (1) exc_i.raise
//    (2) interrupt: MIE & int_ok_i & |(mip_i&mie_i)
//    (3) mret_i
//    Exception and MRET in the same cycle: the exception wins and the MRET is dropped.
//  Interrupt priority: MEI(11) > MSI(3) > MTI(7).
//  ENTER (1 cycle):
//    mepc <= {exc_pc_i[XLEN-1:2],2'b00}
//    mcause <= {1'b0, PadExceptionCode(code)} for exceptions; {1'b1, 31'd11/3/7} for interrupts
//    mtval <= exc_tval_i for exceptions, 0 for interrupts
//    MPIE <= MIE; MIE <= 0
//    target: if mtvec[1:0]==2'b01 and interrupt, {mtvec[XLEN-1:2],2'b00} + 4*cause; else {mtvec[XLEN-1:2],2'b00}
//  RETURN (1 cycle): MIE <= MPIE; MPIE <= 1; target = mepc.
//  Event latching: pc/tval/cause are captured at IDLE exit. Inputs are ignored while busy_o=1.
//  busy_o=1 in ENTER, RETURN and REDIRECT. It rises the cycle after event acceptance (combinational accept visible via state).
//  REDIRECT: redirect_valid_o=1.
//    redirect_pc_o stays stable until redirect_ready_i=1 at posedge; then valid drops and the FSM returns to IDLE.
//    Latency event->valid: 2 cycles.
//  CSR writes (honoured in IDLE only; ignored when busy):
//    0x300 sets MIE=wdata[3], MPIE=wdata[7]
//    0x341 sets mepc={wdata[XLEN-1:2],2'b00}
//    0x342 sets mcause
//    0x343 sets mtval
//    If an event is accepted in the same cycle, the trap update overrides the CSR write.
//  mtvec MODE 2'b10/2'b11 is treated as direct.
//  Mid-sequence reset: returns to reset values on the next edge; any pending redirect is discarded.
// TESTING
//  T1 mtvec=0x8000_0000, MIE=1, exc {1,2} pc=0x100 tval=0xDEAD -> redirect 0x8000_0000;
//     mcause=0x2, mepc=0x100, mtval=0xDEAD, MIE=0, MPIE=1.
//  T2 mtvec=0x8000_0001, MIE=1, mie=3'b010, mip=3'b010, int_ok=1, pc=0x204 -> redirect 0x8000_001C;
//     mcause=0x8000_0007, mepc=0x204, mtval=0.
//  T3 same cycle exc {1,11} + MEIP enabled + mret_i -> mcause=0xB (ECALL_FROM_M_MODE), MRET ignored;
//     then MEIP masked since MIE=0.
//  T4 after T1, mret_i -> redirect 0x100, MIE=1, MPIE=1; MIE=0 blocks interrupts with all mip/mie set.
//  T5 redirect_ready_i low 3 cycles -> valid/pc held stable, busy_o=1;
//     exc raised and CSR write of mepc during wait have no effect.
//  T6 rst_n=0 during REDIRECT -> next edge valid=0, busy=0, mcause=0, MIE=0; no redirect after release.

Source files
------------

// File: rtl/trap_controller.sv
// M-mode trap controller: owns mepc/mcause/mtval/mstatus.{MIE,MPIE}, performs trap
// entry and MRET, and hands the resulting target PC to fetch over a redirect handshake.
module trap_controller #(
    parameter int              XLEN       = 32,
    parameter logic [XLEN-1:0] RESET_MEPC = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [5:0]      exc_i,
    input  logic [XLEN-1:0] exc_pc_i,
    input  logic [XLEN-1:0] exc_tval_i,
    input  logic            mret_i,
    input  logic            int_ok_i,
    input  logic [2:0]      mip_i,
    input  logic [2:0]      mie_i,
    input  logic [XLEN-1:0] mtvec_i,
    input  logic            csr_we_i,
    input  logic [11:0]     csr_addr_i,
    input  logic [XLEN-1:0] csr_wdata_i,
    output logic            redirect_valid_o,
    input  logic            redirect_ready_i,
    output logic [XLEN-1:0] redirect_pc_o,
    output logic            busy_o,
    output logic [XLEN-1:0] mepc_o,
    output logic [XLEN-1:0] mcause_o,
    output logic [XLEN-1:0] mtval_o,
    output logic            mstatus_mie_o,
    output logic            mstatus_mpie_o,
    output logic [1:0]      dbg_state_o
);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_ENTER    = 2'd1,
        S_RETURN   = 2'd2,
        S_REDIRECT = 2'd3
    } state_e;

    localparam logic [XLEN-1:0] ALIGN_MASK = {{(XLEN-2){1'b1}}, 2'b00};

    state_e          state_q, state_d;
    logic [XLEN-1:0] mepc_q, mepc_d;
    logic [XLEN-1:0] mcause_q, mcause_d;
    logic [XLEN-1:0] mtval_q, mtval_d;
    logic            mie_q, mie_d;
    logic            mpie_q, mpie_d;
    logic [XLEN-1:0] ev_pc_q, ev_pc_d;
    logic [XLEN-1:0] ev_cause_q, ev_cause_d;
    logic [XLEN-1:0] ev_tval_q, ev_tval_d;
    logic            ev_int_q, ev_int_d;
    logic [XLEN-1:0] rpc_q, rpc_d;

    logic [2:0]      irq_pend;
    logic            take_irq;
    logic [4:0]      irq_code;
    logic [XLEN-1:0] vec_off;

    always_comb begin
        irq_pend = mip_i & mie_i;
        take_irq = mie_q & int_ok_i & (|irq_pend);
        // Fixed interrupt priority: external, then software, then timer.
        if (irq_pend[2]) begin
            irq_code = 5'd11;
        end else if (irq_pend[0]) begin
            irq_code = 5'd3;
        end else begin
            irq_code = 5'd7;
        end
        vec_off = '0;
        if (ev_int_q && (mtvec_i[1:0] == 2'b01)) begin
            vec_off = {{(XLEN-7){1'b0}}, ev_cause_q[4:0], 2'b00};
        end
    end

    always_comb begin
        state_d    = state_q;
        mepc_d     = mepc_q;
        mcause_d   = mcause_q;
        mtval_d    = mtval_q;
        mie_d      = mie_q;
        mpie_d     = mpie_q;
        ev_pc_d    = ev_pc_q;
        ev_cause_d = ev_cause_q;
        ev_tval_d  = ev_tval_q;
        ev_int_d   = ev_int_q;
        rpc_d      = rpc_q;

        case (state_q)
            S_IDLE: begin
                // Accepting an event suppresses any same-cycle CSR write.
                if (exc_i[5]) begin
                    state_d    = S_ENTER;
                    ev_pc_d    = exc_pc_i & ALIGN_MASK;
                    ev_cause_d = {1'b0, {(XLEN-6){1'b0}}, exc_i[4:0]};
                    ev_tval_d  = exc_tval_i;
                    ev_int_d   = 1'b0;
                end else if (take_irq) begin
                    state_d    = S_ENTER;
                    ev_pc_d    = exc_pc_i & ALIGN_MASK;
                    ev_cause_d = {1'b1, {(XLEN-6){1'b0}}, irq_code};
                    ev_tval_d  = '0;
                    ev_int_d   = 1'b1;
                end else if (mret_i) begin
                    state_d = S_RETURN;
                end else if (csr_we_i) begin
                    case (csr_addr_i)
                        12'h300: begin
                            mie_d  = csr_wdata_i[3];
                            mpie_d = csr_wdata_i[7];
                        end
                        12'h341: mepc_d   = csr_wdata_i & ALIGN_MASK;
                        12'h342: mcause_d = csr_wdata_i;
                        12'h343: mtval_d  = csr_wdata_i;
                        default: ;
                    endcase
                end
            end
            S_ENTER: begin
                mepc_d   = ev_pc_q;
                mcause_d = ev_cause_q;
                mtval_d  = ev_tval_q;
                mpie_d   = mie_q;
                mie_d    = 1'b0;
                rpc_d    = (mtvec_i & ALIGN_MASK) + vec_off;
                state_d  = S_REDIRECT;
            end
            S_RETURN: begin
                mie_d   = mpie_q;
                mpie_d  = 1'b1;
                rpc_d   = mepc_q;
                state_d = S_REDIRECT;
            end
            S_REDIRECT: begin
                // valid/ready: valid stays high and pc stays stable until ready is
                // seen high at a rising edge; that edge completes the transfer.
                if (redirect_ready_i) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            mepc_q     <= RESET_MEPC;
            mcause_q   <= '0;
            mtval_q    <= '0;
            mie_q      <= 1'b0;
            mpie_q     <= 1'b0;
            ev_pc_q    <= '0;
            ev_cause_q <= '0;
            ev_tval_q  <= '0;
            ev_int_q   <= 1'b0;
            rpc_q      <= '0;
        end else begin
            state_q    <= state_d;
            mepc_q     <= mepc_d;
            mcause_q   <= mcause_d;
            mtval_q    <= mtval_d;
            mie_q      <= mie_d;
            mpie_q     <= mpie_d;
            ev_pc_q    <= ev_pc_d;
            ev_cause_q <= ev_cause_d;
            ev_tval_q  <= ev_tval_d;
            ev_int_q   <= ev_int_d;
            rpc_q      <= rpc_d;
        end
    end

    assign redirect_valid_o = (state_q == S_REDIRECT);
    assign busy_o           = (state_q != S_IDLE);
    assign redirect_pc_o    = rpc_q;
    assign mepc_o           = mepc_q;
    assign mcause_o         = mcause_q;
    assign mtval_o          = mtval_q;
    assign mstatus_mie_o    = mie_q;
    assign mstatus_mpie_o   = mpie_q;
    assign dbg_state_o      = state_q;

endmodule

// File: tb/tb_trap_controller.sv
// Bench for trap_controller: directed trap/MRET scenarios with literal expectations,
// then randomized traffic checked every cycle against a transaction-level model.
module tb_trap_controller;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [5:0]  exc_i;
    logic [31:0] exc_pc_i, exc_tval_i, mtvec_i, csr_wdata_i;
    logic        mret_i, int_ok_i, csr_we_i, redirect_ready_i;
    logic [2:0]  mip_i, mie_i;
    logic [11:0] csr_addr_i;
    logic        redirect_valid_o, busy_o, mstatus_mie_o, mstatus_mpie_o;
    logic [31:0] redirect_pc_o, mepc_o, mcause_o, mtval_o;
    logic [1:0]  dbg_state_o;

    int checks   = 0;
    int failures = 0;
    bit cmp_en   = 1'b0;

    always #5 clk = ~clk;

    trap_controller #(.XLEN(32), .RESET_MEPC(32'h0)) dut (
        .clk(clk), .rst_n(rst_n), .exc_i(exc_i), .exc_pc_i(exc_pc_i),
        .exc_tval_i(exc_tval_i), .mret_i(mret_i), .int_ok_i(int_ok_i),
        .mip_i(mip_i), .mie_i(mie_i), .mtvec_i(mtvec_i), .csr_we_i(csr_we_i),
        .csr_addr_i(csr_addr_i), .csr_wdata_i(csr_wdata_i),
        .redirect_valid_o(redirect_valid_o), .redirect_ready_i(redirect_ready_i),
        .redirect_pc_o(redirect_pc_o), .busy_o(busy_o), .mepc_o(mepc_o),
        .mcause_o(mcause_o), .mtval_o(mtval_o), .mstatus_mie_o(mstatus_mie_o),
        .mstatus_mpie_o(mstatus_mpie_o), .dbg_state_o(dbg_state_o)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model (one trap/MRET transaction at a time) ----------------
    logic [31:0] m_mepc, m_mcause, m_mtval, m_rpc;
    logic        m_mie, m_mpie;
    bit          m_pend;
    int          m_age;
    logic [31:0] p_mepc, p_mcause, p_mtval, p_target;
    logic        p_mie, p_mpie;

    function automatic logic [4:0] irq_pick(input logic [2:0] pend);
        int bit_order[3] = '{2, 0, 1};
        int code_of[3]   = '{11, 3, 7};
        for (int k = 0; k < 3; k++) begin
            if (pend[bit_order[k]]) return 5'(code_of[k]);
        end
        return 5'd0;
    endfunction

    always @(posedge clk) begin
        if (!rst_n) begin
            m_mepc = 32'h0; m_mcause = 32'h0; m_mtval = 32'h0; m_rpc = 32'h0;
            m_mie = 1'b0; m_mpie = 1'b0; m_pend = 1'b0; m_age = 0;
        end else if (m_pend) begin
            if (m_age >= 2) begin
                if (redirect_ready_i) m_pend = 1'b0;
            end else begin
                m_age++;
                if (m_age == 2) begin
                    m_mepc = p_mepc; m_mcause = p_mcause; m_mtval = p_mtval;
                    m_mie = p_mie; m_mpie = p_mpie; m_rpc = p_target;
                end
            end
        end else begin
            logic [2:0] pend_bits;
            logic [4:0] code;
            pend_bits = mip_i & mie_i;
            if (exc_i[5]) begin
                p_mepc = {exc_pc_i[31:2], 2'b00};
                p_mcause = {27'd0, exc_i[4:0]};
                p_mtval = exc_tval_i;
                p_mpie = m_mie; p_mie = 1'b0;
                p_target = {mtvec_i[31:2], 2'b00};
                m_pend = 1'b1; m_age = 1;
            end else if (m_mie && int_ok_i && pend_bits != 3'b000) begin
                code = irq_pick(pend_bits);
                p_mepc = {exc_pc_i[31:2], 2'b00};
                p_mcause = 32'h8000_0000 + 32'(code);
                p_mtval = 32'h0;
                p_mpie = m_mie; p_mie = 1'b0;
                p_target = {mtvec_i[31:2], 2'b00} + ((mtvec_i[1:0] == 2'b01) ? 32'(code) * 4 : 32'h0);
                m_pend = 1'b1; m_age = 1;
            end else if (mret_i) begin
                p_mepc = m_mepc; p_mcause = m_mcause; p_mtval = m_mtval;
                p_mie = m_mpie; p_mpie = 1'b1;
                p_target = m_mepc;
                m_pend = 1'b1; m_age = 1;
            end else if (csr_we_i) begin
                if (csr_addr_i == 12'h300) begin
                    m_mie = csr_wdata_i[3]; m_mpie = csr_wdata_i[7];
                end else if (csr_addr_i == 12'h341) m_mepc = {csr_wdata_i[31:2], 2'b00};
                else if (csr_addr_i == 12'h342) m_mcause = csr_wdata_i;
                else if (csr_addr_i == 12'h343) m_mtval = csr_wdata_i;
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (cmp_en) begin
            chk("cyc_valid", 32'(redirect_valid_o), 32'(m_pend && m_age >= 2));
            chk("cyc_busy", 32'(busy_o), 32'(m_pend));
            chk("cyc_rpc", redirect_pc_o, m_rpc);
            chk("cyc_mepc", mepc_o, m_mepc);
            chk("cyc_mcause", mcause_o, m_mcause);
            chk("cyc_mtval", mtval_o, m_mtval);
            chk("cyc_mie", 32'(mstatus_mie_o), 32'(m_mie));
            chk("cyc_mpie", 32'(mstatus_mpie_o), 32'(m_mpie));
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic idle_inputs();
        exc_i = 6'd0; exc_pc_i = 32'h0; exc_tval_i = 32'h0; mret_i = 1'b0;
        int_ok_i = 1'b0; mip_i = 3'd0; mie_i = 3'd0; csr_we_i = 1'b0;
        csr_addr_i = 12'h0; csr_wdata_i = 32'h0; redirect_ready_i = 1'b0;
    endtask

    task automatic csr_write(input logic [11:0] addr, input logic [31:0] data);
        csr_we_i = 1'b1; csr_addr_i = addr; csr_wdata_i = data;
        tick();
        csr_we_i = 1'b0;
    endtask

    task automatic wait_valid(input string name);
        bit ok = 1'b0;
        for (int i = 0; i < 10 && !ok; i++) begin
            if (redirect_valid_o) ok = 1'b1;
            else tick();
        end
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s_timeout actual=no_valid expected=valid_within_10_cycles", name);
        end
    endtask

    task automatic ack();
        redirect_ready_i = 1'b1;
        tick();
        redirect_ready_i = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    logic [31:0] mtvec_tab[4] = '{32'h8000_0000, 32'h8000_0001, 32'h1000_0002, 32'h2000_0103};
    logic [11:0] addr_tab[5]  = '{12'h300, 12'h341, 12'h342, 12'h343, 12'h305};

    initial begin
        rst_n = 1'b0;
        mtvec_i = 32'h8000_0000;
        idle_inputs();
        tick();
        cmp_en = 1'b1;
        tick();
        chk("rst_valid", 32'(redirect_valid_o), 32'h0);
        chk("rst_busy", 32'(busy_o), 32'h0);
        chk("rst_mepc", mepc_o, 32'h0);
        chk("rst_mie", 32'(mstatus_mie_o), 32'h0);
        rst_n = 1'b1;
        tick();

        // T1: synchronous exception, direct mode
        csr_write(12'h300, 32'h8);
        exc_i = {1'b1, 5'd2}; exc_pc_i = 32'h100; exc_tval_i = 32'hDEAD;
        tick();
        exc_i = 6'd0;
        chk("t1_busy_enter", 32'(busy_o), 32'h1);
        chk("t1_valid_enter", 32'(redirect_valid_o), 32'h0);
        tick();
        chk("t1_valid_latency", 32'(redirect_valid_o), 32'h1);
        wait_valid("t1");
        chk("t1_pc", redirect_pc_o, 32'h8000_0000);
        chk("t1_mcause", mcause_o, 32'h2);
        chk("t1_mepc", mepc_o, 32'h100);
        chk("t1_mtval", mtval_o, 32'hDEAD);
        chk("t1_mie", 32'(mstatus_mie_o), 32'h0);
        chk("t1_mpie", 32'(mstatus_mpie_o), 32'h1);
        ack();
        chk("t1_done", 32'(busy_o), 32'h0);

        // T4: MRET back to mepc, then MIE=0 masks every interrupt
        mret_i = 1'b1;
        tick();
        mret_i = 1'b0;
        wait_valid("t4");
        chk("t4_pc", redirect_pc_o, 32'h100);
        chk("t4_mie", 32'(mstatus_mie_o), 32'h1);
        chk("t4_mpie", 32'(mstatus_mpie_o), 32'h1);
        ack();
        csr_write(12'h300, 32'h0);
        mip_i = 3'b111; mie_i = 3'b111; int_ok_i = 1'b1;
        repeat (3) begin
            tick();
            chk("t4_masked", 32'(busy_o), 32'h0);
        end
        idle_inputs();

        // T2: vectored timer interrupt
        csr_write(12'h300, 32'h8);
        mtvec_i = 32'h8000_0001;
        mie_i = 3'b010; mip_i = 3'b010; int_ok_i = 1'b1; exc_pc_i = 32'h204;
        tick();
        idle_inputs();
        wait_valid("t2");
        chk("t2_pc", redirect_pc_o, 32'h8000_001C);
        chk("t2_mcause", mcause_o, 32'h8000_0007);
        chk("t2_mepc", mepc_o, 32'h204);
        chk("t2_mtval", mtval_o, 32'h0);
        ack();

        // T3: exception + interrupt + MRET together; exception wins
        csr_write(12'h300, 32'h8);
        mtvec_i = 32'h8000_0000;
        exc_i = {1'b1, 5'd11}; exc_pc_i = 32'h400; exc_tval_i = 32'h0;
        mip_i = 3'b100; mie_i = 3'b100; int_ok_i = 1'b1; mret_i = 1'b1;
        tick();
        exc_i = 6'd0; mret_i = 1'b0;
        wait_valid("t3");
        chk("t3_mcause", mcause_o, 32'hB);
        chk("t3_pc", redirect_pc_o, 32'h8000_0000);
        chk("t3_mie", 32'(mstatus_mie_o), 32'h0);
        ack();
        repeat (3) begin
            tick();
            chk("t3_meip_masked", 32'(busy_o), 32'h0);
        end
        idle_inputs();

        // T5: backpressure; inputs during the wait must be ignored
        exc_i = {1'b1, 5'd4}; exc_pc_i = 32'h300; exc_tval_i = 32'h55;
        tick();
        exc_i = 6'd0;
        wait_valid("t5");
        repeat (3) begin
            exc_i = {1'b1, 5'd7}; exc_pc_i = 32'h999;
            csr_we_i = 1'b1; csr_addr_i = 12'h341; csr_wdata_i = 32'h4444;
            tick();
            chk("t5_valid_held", 32'(redirect_valid_o), 32'h1);
            chk("t5_busy_held", 32'(busy_o), 32'h1);
            chk("t5_pc_held", redirect_pc_o, 32'h8000_0000);
        end
        idle_inputs();
        chk("t5_mepc", mepc_o, 32'h300);
        chk("t5_mcause", mcause_o, 32'h4);
        ack();
        chk("t5_done", 32'(busy_o), 32'h0);

        // T6: reset while redirect is pending
        exc_i = {1'b1, 5'd5}; exc_pc_i = 32'h40;
        tick();
        exc_i = 6'd0;
        wait_valid("t6");
        rst_n = 1'b0;
        tick();
        chk("t6_valid", 32'(redirect_valid_o), 32'h0);
        chk("t6_busy", 32'(busy_o), 32'h0);
        chk("t6_mcause", mcause_o, 32'h0);
        chk("t6_mie", 32'(mstatus_mie_o), 32'h0);
        rst_n = 1'b1;
        redirect_ready_i = 1'b1;
        repeat (4) begin
            tick();
            chk("t6_no_redirect", 32'(redirect_valid_o), 32'h0);
        end
        idle_inputs();

        // Randomized traffic against the model
        for (int n = 0; n < 3000; n++) begin
            rst_n = ($urandom_range(0, 249) != 0);
            exc_i = {($urandom_range(0, 7) == 0), 5'($urandom_range(0, 31))};
            exc_pc_i = $urandom();
            exc_tval_i = $urandom();
            mret_i = ($urandom_range(0, 7) == 0);
            int_ok_i = 1'($urandom_range(0, 1));
            mip_i = 3'($urandom_range(0, 7));
            mie_i = 3'($urandom_range(0, 7));
            csr_we_i = ($urandom_range(0, 3) == 0);
            csr_addr_i = addr_tab[$urandom_range(0, 4)];
            csr_wdata_i = $urandom();
            redirect_ready_i = 1'($urandom_range(0, 1));
            if (!m_pend && $urandom_range(0, 7) == 0) mtvec_i = mtvec_tab[$urandom_range(0, 3)];
            tick();
        end
        rst_n = 1'b1;
        idle_inputs();
        redirect_ready_i = 1'b1;
        repeat (5) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
